pc_gen: RTL and testbench
=========================

# pc_gen

Program-counter generator for the fetch stage, directly upstream and downstream of the combinational 32-bit `adder` that produces PC+4. It holds the fetch address register, drives the adder operands and loads the adder's sum as the sequential next PC. It also handles branch/jump redirects and stalls, and runs a fetch valid/ready handshake toward instruction memory.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `PC_STEP`, default 32'd4: constant driven on `o_add_b`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_stall`  in  1  hold PC; from the hazard unit.
- `i_br_taken`  in  1  redirect request.
- `i_br_target`  in  32  redirect address.
- `i_imem_ready`  in  1  instruction memory accepts the current fetch.
- `i_add_data`  in  32  sum returned by the adder (`o_add_a + o_add_b`).
- `o_add_a`  out  32  adder operand A; equals `o_pc`, combinational.
- `o_add_b`  out  32  adder operand B; equals `PC_STEP`, constant.
- `o_pc`  out  32  registered fetch address.
- `o_imem_valid`  out  1  fetch request valid.
- `o_misaligned`  out  1  sticky flag: a redirect target had bits [1:0] ≠ 0.

## Operation
- States: `S_BOOT`, `S_FETCH` and `S_HALT`. Reset enters `S_BOOT`.
- `S_BOOT`: `o_imem_valid` is 0 and the PC holds. It always moves to `S_FETCH` on the next edge, so there is exactly one idle cycle after reset release.
- `S_FETCH` priority, evaluated each edge:
  1. `i_br_taken` with `i_br_target[1:0] != 0`: PC holds, `o_misaligned` is set, and the state moves to `S_HALT`.
  2. `i_br_taken` with an aligned target: PC loads `i_br_target`. This overrides `i_stall` and `i_imem_ready`, and the in-flight fetch is abandoned.
  3. `i_stall`: PC holds.
  4. `i_imem_ready`: PC loads `i_add_data`.
  5. Otherwise the PC holds.
- `S_HALT`: `o_imem_valid` is 0 and all inputs are ignored. Only reset exits this state.
- `o_imem_valid` is 1 only in `S_FETCH`. While stalled it stays 1, and the address is stable.
- Arithmetic is modulo 2^32. `o_pc` = 32'hFFFF_FFFC with ready gives next `o_pc` = 32'h0000_0000, with no flag.
- The block never computes PC+4 internally. The next sequential PC is always `i_add_data`.

## Timing
- Reset values (immediate on `i_rst_n` low, independent of the clock): `o_pc` = `RESET_VECTOR`, `o_imem_valid` = 0, `o_misaligned` = 0, state = `S_BOOT`, counter = 0.
- Reset asserted mid-fetch, mid-stall or in `S_HALT`: all outputs return to the reset values asynchronously, and any pending redirect is lost.
- `o_add_a` / `o_add_b` → `i_add_data` form a same-cycle combinational path. `i_add_data` must settle before the edge.
- Redirect latency is 1 cycle: the target appears on `o_pc` the edge after `i_br_taken` is sampled high.
- Handshake: a fetch completes on an edge where `o_imem_valid & i_imem_ready & !i_stall & !i_br_taken`.
- `o_misaligned` rises on the edge that enters `S_HALT` and stays high until reset.

## Configuration
- `PC_GEN_FETCH_CNT_EN` defined:
  - Adds output `o_fetch_cnt` (out, 32): counts completed fetches and redirects.
  - Reset value is 0; it wraps from 32'hFFFF_FFFF to 0.
  - It holds in `S_BOOT`, in `S_HALT` and during stalls.
- `PC_GEN_FETCH_CNT_EN` not defined: the port and counter logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_VECTOR` = 0, then ready held high → `o_imem_valid` is 0 for the first cycle. `o_pc` then steps 0, 4, 8, 12 on consecutive edges.
- `o_pc` = 32'h10 with `i_stall` = 1 for 3 cycles and ready = 1 → `o_pc` stays 32'h10 with valid high. After release, next `o_pc` = 32'h14.
- `i_br_taken` = 1, `i_br_target` = 32'h200, with `i_stall` = 1 in the same cycle → next `o_pc` = 32'h200. The following ready edge gives 32'h204.
- Redirect to 32'hFFFF_FFFC, then ready → `o_pc` = 32'h0, `o_misaligned` = 0.
- `i_br_target` = 32'h102 with `i_br_taken` = 1 → `o_misaligned` = 1, valid = 0, and the PC is frozen for 10 cycles despite later redirects. Asserting `i_rst_n` = 0 mid-cycle then clears all outputs without waiting for a clock edge.
- With `PC_GEN_FETCH_CNT_EN`: 5 ready cycles, then 2 stall cycles, then 1 redirect → `o_fetch_cnt` = 6.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter generator.
//
// Holds the fetch address, feeds the external PC+STEP adder and loads the
// adder's sum as the sequential next PC. Handles branch/jump redirects,
// hazard stalls and a valid/ready fetch handshake toward instruction memory.
// A redirect to a non-word-aligned target freezes the block in S_HALT with
// a sticky o_misaligned flag until reset.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset (must be word-aligned)
//   PC_STEP       constant driven on o_add_b
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_stall       hold PC (hazard unit)
//   i_br_taken    redirect request
//   i_br_target   redirect address
//   i_imem_ready  instruction memory accepts the current fetch
//   i_add_data    adder sum (o_add_a + o_add_b), must settle before the edge
//   o_add_a       adder operand A (= o_pc)
//   o_add_b       adder operand B (= PC_STEP)
//   o_pc          registered fetch address
//   o_imem_valid  fetch request valid
//   o_misaligned  sticky misaligned-redirect flag
//   o_fetch_cnt   completed fetches + redirects (only with PC_GEN_FETCH_CNT_EN)
//
// Build option: define PC_GEN_FETCH_CNT_EN to add the o_fetch_cnt counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_BOOT  | one idle cycle after reset, no fetch request, PC holds
// S_FETCH | fetch request valid; redirect / stall / advance on each edge
// S_HALT  | misaligned redirect seen; frozen until reset

module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_imem_ready,
  input  logic [31:0] i_add_data,
  output logic [31:0] o_add_a,
  output logic [31:0] o_add_b,
  output logic [31:0] o_pc,
  output logic        o_imem_valid,
  output logic        o_misaligned
`ifdef PC_GEN_FETCH_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_misaligned;
  logic        w_misaligned_nxt;
  logic        w_imem_valid;
`ifdef PC_GEN_FETCH_CNT_EN
  logic        w_cnt_inc;
  logic [31:0] r_fetch_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_misaligned_nxt = r_misaligned;
    w_imem_valid     = 1'b0;
`ifdef PC_GEN_FETCH_CNT_EN
    w_cnt_inc        = 1'b0;
`endif
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_imem_valid = 1'b1;
        if (i_br_taken) begin
          if (i_br_target[1:0] != 2'b00) begin
            // PC keeps its last good value so software can see where it died
            w_misaligned_nxt = 1'b1;
            w_state_nxt      = S_HALT;
          end else begin
            // redirect wins over stall and ready; in-flight fetch is dropped
            w_pc_nxt = i_br_target;
`ifdef PC_GEN_FETCH_CNT_EN
            w_cnt_inc = 1'b1;
`endif
          end
        end else if (!i_stall && i_imem_ready) begin
          // sequential PC always comes from the external adder
          w_pc_nxt = i_add_data;
`ifdef PC_GEN_FETCH_CNT_EN
          w_cnt_inc = 1'b1;
`endif
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

`ifdef PC_GEN_FETCH_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_cnt_inc) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
`endif

  assign o_add_a      = r_pc;
  assign o_add_b      = PC_STEP;
  assign o_pc         = r_pc;
  assign o_imem_valid = w_imem_valid;
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_ready;
  logic [31:0] add_data;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] pc;
  logic        imem_valid;
  logic        misaligned;
  logic [31:0] skew;
`ifdef PC_GEN_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_halt;
  logic        m_mis;
  logic [31:0] m_cnt;

  pc_gen dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .i_imem_ready (imem_ready),
    .i_add_data   (add_data),
    .o_add_a      (add_a),
    .o_add_b      (add_b),
    .o_pc         (pc),
    .o_imem_valid (imem_valid),
    .o_misaligned (misaligned)
`ifdef PC_GEN_FETCH_CNT_EN
    ,
    .o_fetch_cnt  (fetch_cnt)
`endif
  );

  // external adder; skew lets the bench prove the PC really comes from i_add_data
  assign add_data = add_a + add_b + skew;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc   = 32'h0;
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_mis  = 1'b0;
    m_cnt  = 32'h0;
  endtask

  // called at posedge+1; pulses reset inside the cycle
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // drive one cycle of inputs, take the edge, advance the model
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] sk);
    logic [31:0] sum;
    stall = st; br_taken = br; br_target = tgt; imem_ready = rdy; skew = sk;
    sum = m_pc + 32'd4 + sk;
    @(posedge clk);
    #1;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      if (br) begin
        if (tgt[1:0] != 2'b00) begin
          m_halt = 1'b1;
          m_mis  = 1'b1;
        end else begin
          m_pc  = tgt;
          m_cnt = m_cnt + 32'd1;
        end
      end else if (!st && rdy) begin
        m_pc  = sum;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
    n_checks++; if (imem_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", imem_valid); else n_pass++;
    n_checks++; if (misaligned !== 1'b0) $display("FAIL reset_mis: got %b want 0", misaligned); else n_pass++;
    n_checks++; if (add_b !== 32'd4) $display("FAIL reset_add_b: got %h want %h", add_b, 32'd4); else n_pass++;
`ifdef PC_GEN_FETCH_CNT_EN
    n_checks++; if (fetch_cnt !== 32'h0) $display("FAIL reset_cnt: got %h want 0", fetch_cnt); else n_pass++;
`endif
    @(posedge clk); #1;
    n_checks++; if (pc !== 32'h0 || imem_valid !== 1'b0) $display("FAIL reset_held: pc %h valid %b want 0/0", pc, imem_valid); else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ready = 1'b1;
    n_checks++; if (imem_valid !== 1'b0) $display("FAIL boot_valid: got %b want 0", imem_valid); else n_pass++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++; if (imem_valid !== 1'b1 || pc !== 32'h0) $display("FAIL seq_first: pc %h valid %b want 0/1", pc, imem_valid); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
      n_checks++; if (pc !== 32'(4 * k)) $display("FAIL seq_step%0d: got %h want %h", k, pc, 32'(4 * k)); else n_pass++;
    end
  endtask

  task automatic test_stall();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++; if (pc !== 32'h10) $display("FAIL stall_pre: got %h want %h", pc, 32'h10); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
      n_checks++; if (pc !== 32'h10 || imem_valid !== 1'b1) $display("FAIL stall_hold%0d: pc %h valid %b want 10/1", k, pc, imem_valid); else n_pass++;
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++; if (pc !== 32'h14) $display("FAIL stall_release: got %h want %h", pc, 32'h14); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    cycle(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);
    n_checks++; if (pc !== 32'h200) $display("FAIL redir_stall: got %h want %h", pc, 32'h200); else n_pass++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++; if (pc !== 32'h204) $display("FAIL redir_next: got %h want %h", pc, 32'h204); else n_pass++;
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_redir: got %h want %h", pc, 32'hFFFF_FFFC); else n_pass++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++; if (pc !== 32'h0 || misaligned !== 1'b0) $display("FAIL wrap: pc %h mis %b want 0/0", pc, misaligned); else n_pass++;
  endtask

  task automatic test_adder_source();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    n_checks++; if (pc !== 32'h44) $display("FAIL adder_src: got %h want %h", pc, 32'h44); else n_pass++;
    n_checks++; if (add_a !== 32'h44) $display("FAIL adder_a: got %h want %h", add_a, 32'h44); else n_pass++;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++; if (pc !== 32'h44) $display("FAIL idle_hold: got %h want %h", pc, 32'h44); else n_pass++;
  endtask

  task automatic test_misaligned();
    cycle(1'b0, 1'b1, 32'h102, 1'b1, 32'h0);
    n_checks++; if (misaligned !== 1'b1 || imem_valid !== 1'b0 || pc !== 32'h44)
      $display("FAIL mis_enter: mis %b valid %b pc %h want 1/0/44", misaligned, imem_valid, pc); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, {$urandom_range(0, 1023), 2'b00}, 1'b1, 32'h0);
      n_checks++; if (pc !== 32'h44 || misaligned !== 1'b1 || imem_valid !== 1'b0)
        $display("FAIL halt_frozen%0d: pc %h mis %b valid %b want 44/1/0", k, pc, misaligned, imem_valid); else n_pass++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0 || misaligned !== 1'b0 || imem_valid !== 1'b0)
      $display("FAIL async_reset: pc %h mis %b valid %b want 0/0/0", pc, misaligned, imem_valid); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic        st, br, rdy;
    logic [31:0] tgt, sk;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      sk  = ($urandom_range(0, 9) == 0) ? {$urandom_range(0, 255), 2'b00} : 32'h0;
      cycle(st, br, tgt, rdy, sk);
      n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc%0d: got %h want %h", k, pc, m_pc); else n_pass++;
      n_checks++; if (imem_valid !== (!m_boot && !m_halt)) $display("FAIL rnd_valid%0d: got %b want %b", k, imem_valid, !m_boot && !m_halt); else n_pass++;
      n_checks++; if (misaligned !== m_mis) $display("FAIL rnd_mis%0d: got %b want %b", k, misaligned, m_mis); else n_pass++;
      n_checks++; if (add_a !== m_pc) $display("FAIL rnd_add_a%0d: got %h want %h", k, add_a, m_pc); else n_pass++;
`ifdef PC_GEN_FETCH_CNT_EN
      n_checks++; if (fetch_cnt !== m_cnt) $display("FAIL rnd_cnt%0d: got %h want %h", k, fetch_cnt, m_cnt); else n_pass++;
`endif
    end
  endtask

`ifdef PC_GEN_FETCH_CNT_EN
  task automatic test_fetch_cnt();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    n_checks++; if (fetch_cnt !== 32'h0) $display("FAIL cnt_boot: got %h want 0", fetch_cnt); else n_pass++;
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h0);
    n_checks++; if (fetch_cnt !== 32'd6) $display("FAIL cnt_total: got %0d want 6", fetch_cnt); else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_ready = 1'b0; skew = 32'h0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_adder_source();
    test_misaligned();
    test_random();
`ifdef PC_GEN_FETCH_CNT_EN
    test_fetch_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
